game_score_keeper: RTL and testbench

//   Parametrised score/lives tracker for the snake game; next generation of the single-life score tracker.

---
 rtl/score_pkg.sv | 16 +
 rtl/rise_detect.sv | 23 ++
 rtl/game_score_keeper.sv | 127 ++++++++++++
 tb/tb_game_score_keeper.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and default sizing for the snake-game score keeper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_state_t;

  localparam int DEF_SCORE_W   = 7;
  localparam int DEF_WIN_SCORE = 99;
  localparam int DEF_LIVES     = 3;
  localparam int DEF_LIVES_W   = 3;

endpackage : score_pkg

// File: rtl/rise_detect.sv
// Turns a level input into a one-cycle pulse on each rising edge.
module rise_detect (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  output logic pulse
);

  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= in;
    end
  end

  // Combinational pulse feeds only the top-level registers, so outputs stay registered.
  assign pulse = in & ~r_prev;

endmodule : rise_detect

// File: rtl/game_score_keeper.sv
// Score, lives and high-score tracker with WIN/LOSE detection for the snake game.
module game_score_keeper
  import score_pkg::*;
#(
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int WIN_SCORE = DEF_WIN_SCORE,
  parameter int LIVES     = DEF_LIVES,
  parameter int LIVES_W   = DEF_LIVES_W
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               goodColl,
  input  logic               badColl,
  output logic [SCORE_W-1:0] currScore,
  output logic [SCORE_W-1:0] highScore,
  output logic [LIVES_W-1:0] livesLeft,
  output logic               isGameComplete,
  output logic               isWin,
  output logic               newHigh
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_VAL = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LAST_LIFE = LIVES_W'(1);

  logic w_good_ev;
  logic w_bad_ev;
  logic w_start_ev;

  rise_detect u_good_edge (
    .clk   (clk),
    .nRst  (nRst),
    .in    (goodColl),
    .pulse (w_good_ev)
  );

  rise_detect u_bad_edge (
    .clk   (clk),
    .nRst  (nRst),
    .in    (badColl),
    .pulse (w_bad_ev)
  );

  rise_detect u_start_edge (
    .clk   (clk),
    .nRst  (nRst),
    .in    (start),
    .pulse (w_start_ev)
  );

  game_state_t        r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [LIVES_W-1:0] r_lives;
  logic               r_complete;
  logic               r_win;
  logic               r_new_high;

  logic [SCORE_W-1:0] w_score_inc;
  logic               w_beats_high;

  assign w_score_inc  = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
  assign w_beats_high = (w_score_inc > r_high);

  // Flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state    <= PLAY;
      r_score    <= '0;
      r_high     <= '0;
      r_lives    <= LIVES_VAL;
      r_complete <= 1'b0;
      r_win      <= 1'b0;
      r_new_high <= 1'b0;
    end else begin
      r_new_high <= 1'b0;
      case (r_state)
        PLAY: begin
          // A hit in the same cycle as an apple takes priority; the apple is dropped.
          if (w_bad_ev) begin
            r_lives <= r_lives - LIVES_W'(1);
            if (r_lives == LAST_LIFE) begin
              r_state    <= LOSE;
              r_complete <= 1'b1;
            end
          end else if (w_good_ev) begin
            r_score <= w_score_inc;
            if (w_beats_high) begin
              r_high     <= w_score_inc;
              r_new_high <= 1'b1;
            end
            if (w_score_inc == WIN_VAL) begin
              r_state    <= WIN;
              r_complete <= 1'b1;
              r_win      <= 1'b1;
            end
          end
        end
        WIN, LOSE: begin
          if (w_start_ev) begin
            r_state    <= IDLE;
            r_score    <= '0;
            r_lives    <= LIVES_VAL;
            r_complete <= 1'b0;
            r_win      <= 1'b0;
          end
        end
        IDLE: begin
          r_state <= PLAY;
        end
        default: begin
          r_state <= PLAY;
        end
      endcase
    end
  end

  assign currScore      = r_score;
  assign highScore      = r_high;
  assign livesLeft      = r_lives;
  assign isGameComplete = r_complete;
  assign isWin          = r_win;
  assign newHigh        = r_new_high;

endmodule : game_score_keeper

// File: tb/tb_game_score_keeper.sv
// Self-checking bench: two DUTs (WIN_SCORE 99 and 4) against a behavioural game model.
module tb_game_score_keeper;

  localparam int M_PLAY = 0;
  localparam int M_WIN  = 1;
  localparam int M_LOSE = 2;
  localparam int M_IDLE = 3;

  typedef struct {
    int mode;
    int score;
    int high;
    int lives;
    bit nh;
    bit pg;
    bit pb;
    bit ps;
  } mdl_t;

  logic clk = 1'b0;
  logic nRst, start, goodColl, badColl;

  logic [6:0] cs_a, hs_a, cs_b, hs_b;
  logic [2:0] ll_a, ll_b;
  logic       gc_a, w_a, nh_a, gc_b, w_b, nh_b;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en   = 1'b0;
  mdl_t m[2];
  int   win_of[2] = '{99, 4};

  game_score_keeper #(.WIN_SCORE(99)) u_dut_a (
    .clk(clk), .nRst(nRst), .start(start), .goodColl(goodColl), .badColl(badColl),
    .currScore(cs_a), .highScore(hs_a), .livesLeft(ll_a),
    .isGameComplete(gc_a), .isWin(w_a), .newHigh(nh_a)
  );

  game_score_keeper #(.WIN_SCORE(4)) u_dut_b (
    .clk(clk), .nRst(nRst), .start(start), .goodColl(goodColl), .badColl(badColl),
    .currScore(cs_b), .highScore(hs_b), .livesLeft(ll_b),
    .isGameComplete(gc_b), .isWin(w_b), .newHigh(nh_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t s, input int win, input bit rst_n,
                                input bit g, input bit b, input bit st);
    mdl_t n;
    bit   ge, be, se;
    n = s;
    if (!rst_n) begin
      n.mode = M_PLAY; n.score = 0; n.high = 0; n.lives = 3; n.nh = 0;
      n.pg = 0; n.pb = 0; n.ps = 0;
      return n;
    end
    ge = g && !s.pg;
    be = b && !s.pb;
    se = st && !s.ps;
    n.pg = g; n.pb = b; n.ps = st; n.nh = 0;
    case (s.mode)
      M_PLAY: begin
        if (be) begin
          n.lives = s.lives - 1;
          if (n.lives == 0) n.mode = M_LOSE;
        end else if (ge) begin
          n.score = (s.score >= 127) ? 127 : s.score + 1;
          if (n.score > s.high) begin
            n.high = n.score;
            n.nh   = 1;
          end
          if (n.score == win) n.mode = M_WIN;
        end
      end
      M_WIN, M_LOSE: begin
        if (se) begin
          n.mode = M_IDLE; n.score = 0; n.lives = 3;
        end
      end
      default: n.mode = M_PLAY;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) m[k] = step(m[k], win_of[k], nRst, goodColl, badColl, start);
  end

  task automatic cmp(input string tag, input int idx, input logic [6:0] cs, input logic [6:0] hs,
                     input logic [2:0] ll, input logic gc, input logic w, input logic nh);
    check({tag, ".currScore"},      int'(cs), m[idx].score);
    check({tag, ".highScore"},      int'(hs), m[idx].high);
    check({tag, ".livesLeft"},      int'(ll), m[idx].lives);
    check({tag, ".isGameComplete"}, int'(gc), int'(m[idx].mode == M_WIN || m[idx].mode == M_LOSE));
    check({tag, ".isWin"},          int'(w),  int'(m[idx].mode == M_WIN));
    check({tag, ".newHigh"},        int'(nh), int'(m[idx].nh));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("a", 0, cs_a, hs_a, ll_a, gc_a, w_a, nh_a);
      cmp("b", 1, cs_b, hs_b, ll_b, gc_b, w_b, nh_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic good_edge();
    goodColl = 1'b1; tick();
    goodColl = 1'b0; tick();
  endtask

  initial begin
    nRst = 1'b0; start = 1'b0; goodColl = 1'b0; badColl = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    nRst = 1'b1;
    check("reset.currScore", int'(cs_a), 0);
    check("reset.highScore", int'(hs_a), 0);
    check("reset.livesLeft", int'(ll_a), 3);
    check("reset.complete",  int'(gc_a), 0);

    // Held level counts once; score and high score move on the same edge.
    goodColl = 1'b1; tick();
    check("hold.score1",  int'(cs_a), 1);
    check("hold.high1",   int'(hs_a), 1);
    check("hold.newHigh", int'(nh_a), 1);
    tick();
    check("hold.newHigh_drop", int'(nh_a), 0);
    tick();
    check("hold.score_still1", int'(cs_a), 1);
    goodColl = 1'b0; tick();
    for (int i = 0; i < 4; i++) good_edge();
    check("toggle.score5", int'(cs_a), 5);

    for (int i = 0; i < 3; i++) begin
      badColl = 1'b1; tick();
      check($sformatf("bad.lives%0d", i), int'(ll_a), 2 - i);
      badColl = 1'b0; tick();
    end
    check("lose.complete", int'(gc_a), 1);
    check("lose.isWin",    int'(w_a),  0);
    good_edge();
    check("lose.frozen_score", int'(cs_a), 5);

    start = 1'b1; tick();
    start = 1'b0; tick();
    check("restart.score",    int'(cs_a), 0);
    check("restart.lives",    int'(ll_a), 3);
    check("restart.high",     int'(hs_a), 5);
    check("restart.complete", int'(gc_a), 0);
    for (int i = 0; i < 2; i++) begin
      goodColl = 1'b1; tick();
      check("replay.no_newHigh", int'(nh_a), 0);
      goodColl = 1'b0; tick();
    end
    check("replay.score2", int'(cs_a), 2);
    check("replay.high5",  int'(hs_a), 5);

    // Fresh game on the WIN_SCORE=4 instance.
    nRst = 1'b0; tick();
    nRst = 1'b1;
    goodColl = 1'b1; badColl = 1'b1; tick();
    check("both.lives", int'(ll_b), 2);
    check("both.score", int'(cs_b), 0);
    goodColl = 1'b0; badColl = 1'b0; tick();
    for (int i = 0; i < 3; i++) good_edge();
    check("pre_win.score3", int'(cs_b), 3);
    check("pre_win.not_done", int'(gc_b), 0);
    good_edge();
    check("win.isWin",    int'(w_b),  1);
    check("win.complete", int'(gc_b), 1);
    check("win.high4",    int'(hs_b), 4);
    good_edge();
    check("win.frozen_score", int'(cs_b), 4);

    nRst = 1'b0; tick();
    nRst = 1'b1;
    for (int i = 0; i < 3; i++) good_edge();
    check("mid.score3", int'(cs_a), 3);
    nRst = 1'b0; tick();
    check("midrst.score", int'(cs_a), 0);
    check("midrst.high",  int'(hs_a), 0);
    check("midrst.lives", int'(ll_a), 3);
    check("midrst.complete", int'(gc_a), 0);
    nRst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      goodColl = 1'($urandom_range(0, 1));
      badColl  = ($urandom_range(0, 15) == 0);
      start    = ($urandom_range(0, 31) == 0);
      nRst     = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_game_score_keeper
